// File: rtl/gshare_index_gen.sv
// Speculative global history and gshare index generation for a 2-bit PHT.
// Tracks in-flight predictions, issues PHT updates at resolve and repairs history on mispredict.
module gshare_index_gen #(
    parameter int INDEX_WIDTH = 12,
    parameter int GHR_WIDTH   = 12,
    parameter int PC_WIDTH    = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   fetch_br_valid_i,
    input  logic [PC_WIDTH-1:0]    fetch_pc_i,
    output logic                   fetch_ready_o,
    output logic [INDEX_WIDTH-1:0] rd_index_o,
    input  logic                   pht_pred_i,
    input  logic                   resolve_valid_i,
    input  logic                   resolve_taken_i,
    output logic                   mispredict_o,
    output logic                   update_en_o,
    output logic [INDEX_WIDTH-1:0] update_index_o,
    output logic                   br_taken_o,
    output logic [GHR_WIDTH-1:0]   ghr_o,
    output logic                   underflow_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [GHR_WIDTH-1:0]   ghr_q, ghr_d;
    logic [INDEX_WIDTH-1:0] idx_mem_q [FIFO_DEPTH];
    logic [INDEX_WIDTH-1:0] idx_mem_d [FIFO_DEPTH];
    logic [GHR_WIDTH-1:0]   snap_mem_q [FIFO_DEPTH];
    logic [GHR_WIDTH-1:0]   snap_mem_d [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  pred_mem_q, pred_mem_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   update_en_q, update_en_d;
    logic [INDEX_WIDTH-1:0] update_index_q, update_index_d;
    logic                   br_taken_q, br_taken_d;
    logic                   underflow_q, underflow_d;

    logic [INDEX_WIDTH-1:0] ghr_ext;
    logic                   push, pop, mispredict;
    logic [INDEX_WIDTH-1:0] head_idx;
    logic [GHR_WIDTH-1:0]   head_snap;
    logic                   head_pred;
    logic                   unused_pc_bits;

    // Only PC[INDEX_WIDTH+1:2] feeds the index; the rest is folded away here.
    assign unused_pc_bits = ^fetch_pc_i;

    always_comb begin
        ghr_ext = '0;
        ghr_ext[GHR_WIDTH-1:0] = ghr_q;
        rd_index_o = fetch_pc_i[INDEX_WIDTH+1:2] ^ ghr_ext;
    end

    assign fetch_ready_o = (count_q != CNT_W'(FIFO_DEPTH));
    assign push          = fetch_br_valid_i && fetch_ready_o;
    assign pop           = resolve_valid_i && (count_q != '0);
    assign head_idx      = idx_mem_q[rd_ptr_q];
    assign head_snap     = snap_mem_q[rd_ptr_q];
    assign head_pred     = pred_mem_q[rd_ptr_q];
    assign mispredict    = pop && (resolve_taken_i != head_pred);

    always_comb begin
        ghr_d          = ghr_q;
        idx_mem_d      = idx_mem_q;
        snap_mem_d     = snap_mem_q;
        pred_mem_d     = pred_mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        update_en_d    = pop;
        update_index_d = update_index_q;
        br_taken_d     = br_taken_q;
        underflow_d    = underflow_q | (resolve_valid_i && (count_q == '0));

        if (pop) begin
            update_index_d = head_idx;
            br_taken_d     = resolve_taken_i;
        end

        // A mispredict flushes everything younger, including a same-cycle push.
        if (mispredict) begin
            ghr_d    = (head_snap << 1) | GHR_WIDTH'(resolve_taken_i);
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) begin
                idx_mem_d[wr_ptr_q]  = rd_index_o;
                snap_mem_d[wr_ptr_q] = ghr_q;
                pred_mem_d[wr_ptr_q] = pht_pred_i;
                wr_ptr_d             = wr_ptr_q + PTR_W'(1);
                ghr_d                = (ghr_q << 1) | GHR_WIDTH'(pht_pred_i);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ghr_q          <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                idx_mem_q[i]  <= '0;
                snap_mem_q[i] <= '0;
            end
            pred_mem_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            update_en_q    <= 1'b0;
            update_index_q <= '0;
            br_taken_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            ghr_q          <= ghr_d;
            idx_mem_q      <= idx_mem_d;
            snap_mem_q     <= snap_mem_d;
            pred_mem_q     <= pred_mem_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            update_en_q    <= update_en_d;
            update_index_q <= update_index_d;
            br_taken_q     <= br_taken_d;
            underflow_q    <= underflow_d;
        end
    end

    assign mispredict_o   = mispredict;
    assign update_en_o    = update_en_q;
    assign update_index_o = update_index_q;
    assign br_taken_o     = br_taken_q;
    assign ghr_o          = ghr_q;
    assign underflow_o    = underflow_q;
endmodule

// File: doc/gshare_index_gen.md
Name: gshare_index_gen

Overview:
- Upstream companion of the 2-bit pattern history table in the Two_Bit_Predict branch predictor.
- Holds the speculative global history register (GHR) and forms the gshare read index as PC XOR GHR for the PHT read port.
- Tracks in-flight predicted branches in a small FIFO.
- At branch resolution it drives the PHT update port (enable, index, outcome), flags mispredictions and repairs the GHR.

Parameters:
- INDEX_WIDTH, 12, PHT index width; must match the PHT.
- GHR_WIDTH, 12, global history length; 1 <= GHR_WIDTH <= INDEX_WIDTH.
- PC_WIDTH, 32, fetch PC width; must be >= INDEX_WIDTH+2.
- FIFO_DEPTH, 4, maximum in-flight branches; power of two, >= 2.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  asynchronous active-high reset.
- fetch_br_valid_i  input  1  fetch stage presents a branch this cycle.
- fetch_pc_i  input  PC_WIDTH  PC of that branch.
- fetch_ready_o  output  1  block can accept a branch.
- rd_index_o  output  INDEX_WIDTH  PHT read index (combinational).
- pht_pred_i  input  1  PHT prediction bit for rd_index_o (asynchronous read, same cycle).
- resolve_valid_i  input  1  oldest in-flight branch resolved this cycle.
- resolve_taken_i  input  1  actual outcome.
- mispredict_o  output  1  combinational; resolved outcome differs from the stored prediction.
- update_en_o  output  1  PHT update enable (registered).
- update_index_o  output  INDEX_WIDTH  PHT update index (registered).
- br_taken_o  output  1  PHT update outcome (registered).
- ghr_o  output  GHR_WIDTH  current speculative GHR (debug).
- underflow_o  output  1  sticky flag: resolve seen with FIFO empty.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous, active-high.
- Reset values: GHR=0, FIFO empty (count=0, pointers=0), update_en_o=0, update_index_o=0, br_taken_o=0, underflow_o=0. fetch_ready_o=1 after reset.
- Read index: rd_index_o = fetch_pc_i[INDEX_WIDTH+1:2] XOR zero-extended GHR. Combinational, valid every cycle regardless of valid inputs.
- Accept: push = fetch_br_valid_i && fetch_ready_o, where fetch_ready_o = (count != FIFO_DEPTH).
- On push:
  - Write entry {rd_index_o, GHR (pre-shift snapshot), pht_pred_i} at the write pointer.
  - Next GHR = {GHR[GHR_WIDTH-2:0], pht_pred_i}; for GHR_WIDTH=1, GHR = pht_pred_i.
- Resolve: pop = resolve_valid_i && (count != 0). The head entry supplies index, snapshot and pred.
  - mispredict_o = pop && (resolve_taken_i != head.pred); 0 when not popping.
  - Next cycle: update_en_o=1, update_index_o=head.index, br_taken_o=resolve_taken_i.
  - update_en_o is a one-cycle pulse per pop; it is 0 in all other cycles, with index and taken holding their last values.
- Mispredict recovery (same edge as the pop):
  - Next GHR = {head.snapshot[GHR_WIDTH-2:0], resolve_taken_i}.
  - FIFO is flushed to empty: count=0, read pointer = write pointer.
- Simultaneous push and correct pop: both occur; count unchanged; GHR takes the push shift.
- Simultaneous push and mispredicting pop:
  - Recovery wins; the pushed branch is dropped (wrong path); GHR takes the recovery value.
  - The PHT update for the popped entry is still issued.
- Fetch while full: fetch_ready_o=0, no push, GHR unchanged. A pop in the same cycle does not allow the push (ready is based on pre-pop count).
- Resolve while empty: ignored; no update, mispredict_o=0; underflow_o set, and it stays set until reset.
- Pointers wrap modulo FIFO_DEPTH. Count ranges 0..FIFO_DEPTH (width clog2(FIFO_DEPTH)+1).
- Reset asserted mid-operation: immediately returns all state to reset values; in-flight entries are discarded.

Test Plan:
- Reset, then idle 3 cycles -> rd_index_o=fetch_pc_i[13:2], ghr_o=0, fetch_ready_o=1, update_en_o=0, underflow_o=0.
- Fetch pc=0x1000 with pht_pred_i=1 -> rd_index_o=0x400, next cycle ghr_o=0x001. Fetch pc=0x1000 again with pred=0 -> rd_index_o=0x401, then ghr_o=0x002.
- Push branch (index 0x400, pred 1); resolve taken=1 -> mispredict_o=0, next cycle update_en_o=1, update_index_o=0x400, br_taken_o=1, then update_en_o=0.
- Push two branches, both pred 1 (GHR 0->1->3); resolve first with taken=0 -> mispredict_o=1, next cycle ghr_o=0x000, fetch_ready_o=1, update_index_o=0x400, br_taken_o=0. A following resolve is flagged as underflow.
- Push 4 branches -> fetch_ready_o=0. A 5th fetch is not accepted and ghr_o stays unchanged. Resolve once (correct) -> fetch_ready_o=1 the next cycle.
- Resolve with FIFO empty -> update_en_o stays 0, underflow_o=1 and held. Assert rst_i asynchronously mid-cycle -> underflow_o=0 and ghr_o=0 without waiting for a clock edge.
